// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the core front end.
//   - fetch_state_e : fetch FSM states
//   - NOP_INSTR     : value held in the instruction register after reset
//   - XLEN          : architectural register / address width
//   - *_LSB/*_MSB   : bit positions of the opcode, funct3 and funct7 fields
//   - is_word_aligned() : true when an address has its low two bits clear
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load enable and next-PC select.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_load            : update the PC this cycle
//   i_sel_target      : 1 = load i_target, 0 = load PC + 4
//   i_target          : redirect address (already checked for alignment)
//   o_pc, o_pcplus4   : current PC and PC + 4 (wraps modulo 2^32)
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_sel_target,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcplus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pcplus4;
  logic [XLEN-1:0] w_next_pc;

  assign w_pcplus4 = r_pc + 32'd4;

  // Next-PC mux: redirect target or sequential successor.
  always_comb begin
    w_next_pc = w_pcplus4;
    if (i_sel_target) begin
      w_next_pc = i_target;
    end else begin
      w_next_pc = w_pcplus4;
    end
  end

  // PC register, loaded only when the fetch FSM retires an instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_next_pc;
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc      = r_pc;
  assign o_pcplus4 = w_pcplus4;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   imem_req/imem_addr                : fetch request and address (= pc)
//   imem_ack/imem_rdata               : memory response
//   instr_valid/instr_ready           : handshake with the decoder
//   branch_taken/branch_target        : redirect, sampled only on consume
//   instr, op, funct3, funct7         : held instruction and its fields
//   pc, pcplus4                       : address of held/fetched instruction
//   misalign                          : sticky misaligned-redirect flag
//   retired                           : wrapping count of consumed instructions
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        misalign,
  output logic [31:0] retired
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_retired;
  logic         r_misalign;
  logic         w_capture;
  logic         w_consume;
  logic         w_pc_load;
  logic         w_pc_sel_target;
  logic         w_misalign_set;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_pc_load),
    .i_sel_target (w_pc_sel_target),
    .i_target     (branch_target),
    .o_pc         (pc),
    .o_pcplus4    (pcplus4)
  );

  // Next-state and control decode.
  always_comb begin
    w_next_state    = r_state;
    w_capture       = 1'b0;
    w_consume       = 1'b0;
    w_pc_load       = 1'b0;
    w_pc_sel_target = 1'b0;
    w_misalign_set  = 1'b0;
    case (r_state)
      ST_START: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_capture    = 1'b1;
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          w_consume = 1'b1;
          // A misaligned redirect halts with the PC left on the offender.
          if (branch_taken && !is_word_aligned(branch_target)) begin
            w_misalign_set = 1'b1;
            w_next_state   = ST_HALT;
          end else begin
            w_pc_load       = 1'b1;
            w_pc_sel_target = branch_taken;
            w_next_state    = ST_FETCH;
          end
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_HALT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction register, retired counter and sticky misalign flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr    <= NOP_INSTR;
      r_retired  <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_instr    <= w_capture ? imem_rdata : r_instr;
      r_retired  <= w_consume ? (r_retired + 32'd1) : r_retired;
      r_misalign <= r_misalign | w_misalign_set;
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_HOLD);
  assign imem_addr   = pc;
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign funct3      = r_instr[F3_MSB:F3_LSB];
  assign funct7      = r_instr[F7_MSB:F7_LSB];
  assign misalign    = r_misalign;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        misalign;
  logic [31:0] retired;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .op(op), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pcplus4(pcplus4), .misalign(misalign), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch stage should be doing at a spec level.
  int          m_phase;     // 0 idle after reset, 1 fetching, 2 holding, 3 halted
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  logic        m_mis;
  int          wait_cnt;
  int          ack_delay;

  typedef struct {
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic [31:0] exp_ret;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_pc     = 32'h0;
    m_instr  = 32'h0000_0013;
    m_ret    = 32'h0;
    m_mis    = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic check_model();
    logic [31:0] ins;
    ins = m_instr;
    chk("req",      imem_req,    (m_phase == 1));
    chk("valid",    instr_valid, (m_phase == 2));
    chk("req_and_valid", imem_req & instr_valid, 32'h0);
    chk("pc",       pc,        m_pc);
    chk("addr",     imem_addr, m_pc);
    chk("pcplus4",  pcplus4,   m_pc + 32'd4);
    chk("instr",    instr,     ins);
    chk("op",       op,        ins[6:0]);
    chk("funct3",   funct3,    ins[14:12]);
    chk("funct7",   funct7,    ins[31:25]);
    chk("misalign", misalign,  m_mis);
    chk("retired",  retired,   m_ret);
  endtask

  // Called at a falling edge: check, drive inputs, predict, advance one cycle.
  task automatic do_cycle(input logic rdy, input logic bt, input logic [31:0] tgt);
    check_model();
    instr_ready   = rdy;
    branch_taken  = bt;
    branch_target = tgt;
    imem_ack      = 1'b0;
    imem_rdata    = $urandom;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end
    case (m_phase)
      0: m_phase = 1;
      1: if (imem_ack) begin m_instr = mem_word(m_pc); m_phase = 2; end
      2: if (rdy) begin
           m_ret = m_ret + 32'd1;
           if (bt && (tgt % 4 != 0)) begin m_mis = 1'b1; m_phase = 3; end
           else begin m_pc = bt ? tgt : m_pc + 32'd4; m_phase = 1; end
         end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 20 && !instr_valid; i++) do_cycle(1'b0, 1'b0, 32'h0);
    chk("hold_reached", instr_valid, 32'h1);
  endtask

  logic [31:0] saved_pc;
  logic [31:0] saved_instr;
  logic [31:0] t;

  initial begin
    vecs[0] = '{1'b0, 32'h0,         32'h0000_0004, 32'd1};
    vecs[1] = '{1'b0, 32'h0,         32'h0000_0008, 32'd2};
    vecs[2] = '{1'b1, 32'h40,        32'h0000_0040, 32'd3};
    vecs[3] = '{1'b0, 32'h0,         32'h0000_0044, 32'd4};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd5};
    vecs[5] = '{1'b0, 32'h0,         32'h0000_0000, 32'd6};
    vecs[6] = '{1'b1, 32'h100,       32'h0000_0100, 32'd7};

    // Reset release and first fetch with zero-wait memory.
    ack_delay = 0;
    do_reset();
    chk("start_req", imem_req, 32'h0);
    chk("start_valid", instr_valid, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0);
    chk("first_req", imem_req, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0);
    chk("first_valid", instr_valid, 32'h1);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_op", op, 32'h13);
    chk("first_f3", funct3, 32'h0);
    chk("first_f7", funct7, 32'h0);

    // Sequential, redirect and wrap vectors.
    for (int i = 0; i < 7; i++) begin
      wait_hold();
      do_cycle(1'b1, vecs[i].bt, vecs[i].tgt);
      chk("vec_addr",  imem_addr,   vecs[i].exp_addr);
      chk("vec_req",   imem_req,    32'h1);
      chk("vec_valid", instr_valid, 32'h0);
      chk("vec_ret",   retired,     vecs[i].exp_ret);
    end

    // Wait states and backpressure; branch pulses outside a consume are ignored.
    ack_delay = 3;
    do_cycle(1'b0, 1'b1, 32'h200);
    wait_hold();
    saved_pc = pc;
    saved_instr = instr;
    for (int i = 0; i < 5; i++) do_cycle(1'b0, (i == 2), 32'h80);
    chk("bp_instr_stable", instr, saved_instr);
    chk("bp_pc_stable", pc, saved_pc);
    chk("bp_no_fetch", imem_req, 32'h0);
    do_cycle(1'b1, 1'b0, 32'h0);
    chk("bp_next_addr", imem_addr, saved_pc + 32'd4);

    // Asynchronous reset in FETCH with an ack in the same cycle.
    ack_delay = 0;
    chk("pre_rst_req", imem_req, 32'h1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_valid", instr_valid, 32'h0);
    chk("arst_req", imem_req, 32'h0);
    chk("arst_ret", retired, 32'h0);
    @(negedge clk);
    chk("arst_ack_ignored", instr, 32'h0000_0013);
    do_reset();

    // Misaligned redirect halts until reset.
    wait_hold();
    do_cycle(1'b1, 1'b0, 32'h0);
    wait_hold();
    saved_pc = pc;
    do_cycle(1'b1, 1'b1, 32'h42);
    chk("mis_flag", misalign, 32'h1);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 32'h0);
    chk("mis_pc", pc, saved_pc);
    chk("mis_req", imem_req, 32'h0);
    do_reset();
    chk("mis_cleared", misalign, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ack_delay = $urandom_range(0, 2);
      t = $urandom;
      if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
      do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, t);
      if (m_phase == 3) begin
        do_cycle(1'b0, 1'b0, 32'h0);
        do_reset();
      end
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
